// File: rtl/rsa_addsub_ctrl.sv
// Initiator and data mover for the word-serial RSA add/sub unit: operand buffers, start pulse, result capture and readback.
// Optional protocol checker enabled by defining RSA_ADDSUB_CTRL_PROTO_CHECK_EN.
module rsa_addsub_ctrl #(
    parameter int WORDS = 32,
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iLoadA,
    input  logic             iLoadB,
    input  logic [WIDTH-1:0] iLoadData,
    input  logic             iGo,
    input  logic             iOp,
    output logic             oBusy,
    output logic             oStart,
    output logic             oAddSub,
    output logic [WIDTH-1:0] oA,
    output logic [WIDTH-1:0] oB,
    input  logic             iDataShift,
    input  logic [WIDTH-1:0] iD,
    input  logic             iCarry,
    input  logic             iDone,
    output logic             oDoneP,
    output logic             oCarry,
    output logic [WIDTH-1:0] oResWord,
    input  logic             iResPop,
    output logic             oProtoErr
);

    localparam int TOP = WORDS * WIDTH - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state;
    logic [TOP:0] buf_a;
    logic [TOP:0] buf_b;
    logic [TOP:0] buf_r;
    logic busy;

    assign busy     = (state == S_START) || (state == S_RUN);
    assign oBusy    = busy;
    assign oStart   = (state == S_START);
    assign oA       = buf_a[WIDTH-1:0];
    assign oB       = buf_b[WIDTH-1:0];
    assign oResWord = buf_r[WIDTH-1:0];

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state   <= S_IDLE;
            buf_a   <= '0;
            buf_b   <= '0;
            buf_r   <= '0;
            oAddSub <= 1'b0;
            oCarry  <= 1'b0;
            oDoneP  <= 1'b0;
        end else begin
            oDoneP <= 1'b0;
            // Operands leave LS word first while the result fills from the top.
            if (busy && iDataShift) begin
                buf_a <= {{WIDTH{1'b0}}, buf_a[TOP:WIDTH]};
                buf_b <= {{WIDTH{1'b0}}, buf_b[TOP:WIDTH]};
                buf_r <= {iD, buf_r[TOP:WIDTH]};
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (iGo) begin
                        state   <= S_START;
                        oAddSub <= iOp;
                    end else begin
                        if (iLoadA) buf_a <= {iLoadData, buf_a[TOP:WIDTH]};
                        if (iLoadB) buf_b <= {iLoadData, buf_b[TOP:WIDTH]};
                        if (iResPop && (state == S_DONE))
                            buf_r <= {{WIDTH{1'b0}}, buf_r[TOP:WIDTH]};
                    end
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (iDataShift && iDone) begin
                        state  <= S_DONE;
                        oCarry <= iCarry;
                        oDoneP <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RSA_ADDSUB_CTRL_PROTO_CHECK_EN
    localparam int CW = $clog2(WORDS + 2);

    logic [CW-1:0] shift_cnt;
    logic [CW-1:0] shift_num;

    // Ordinal of the shift happening this cycle, counting the START shift as 1.
    assign shift_num = (state == S_START) ? CW'(1) : shift_cnt + CW'(1);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            shift_cnt <= '0;
            oProtoErr <= 1'b0;
        end else begin
            if (state == S_START)
                shift_cnt <= iDataShift ? CW'(1) : '0;
            else if ((state == S_RUN) && iDataShift && (shift_cnt != CW'(WORDS)))
                shift_cnt <= shift_num;
            if ((busy && !iDataShift) || (!busy && iDataShift) ||
                (busy && iDataShift && iDone && (shift_num != CW'(WORDS))))
                oProtoErr <= 1'b1;
        end
    end
`else
    assign oProtoErr = 1'b0;
`endif

endmodule
